// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter that applies SR commands to a shared T-flip-flop flag bank
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/set/clr    per-requester command valid, S bit, R bit
//   req_idx              per-requester flag index, slice i at [i*IDXW +: IDXW]
//   gnt                  one-hot grant (combinational), transfer on req_valid[i] & gnt[i]
//   flags                flag bank Q
//   done_vld/src/chg     one-cycle pulse when a command is applied, its source, whether it toggled
//   err, err_clr         sticky error (bad index or set&clr), synchronous clear
//   SR_FLAG_TOGGLE_EN    when defined, set&clr toggles the flag (JK-style) instead of flagging an error
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NREQ-1:0]                   req_valid,
    input  logic [NREQ-1:0]                   req_set,
    input  logic [NREQ-1:0]                   req_clr,
    input  logic [NREQ*$clog2(NFLAG)-1:0]     req_idx,
    output logic [NREQ-1:0]                   gnt,
    output logic [NFLAG-1:0]                  flags,
    output logic                              done_vld,
    output logic [$clog2(NREQ)-1:0]           done_src,
    output logic                              done_chg,
    output logic                              err,
    input  logic                              err_clr
);
    localparam int IDXW = $clog2(NFLAG);
    localparam int SRCW = $clog2(NREQ);

    logic [SRCW-1:0]  rr_ptr_q, rr_ptr_d, win, cand;
    logic             any;
    logic             op_vld_q, op_vld_d, op_set_q, op_set_d, op_clr_q, op_clr_d;
    logic [IDXW-1:0]  op_idx_q, op_idx_d;
    logic [SRCW-1:0]  op_src_q, op_src_d;
    logic [NFLAG-1:0] flags_q, flags_d;
    logic             done_vld_q, done_vld_d, done_chg_q, done_chg_d, err_q, err_d;
    logic [SRCW-1:0]  done_src_q, done_src_d;
    logic             in_rng, q_bit, t_bit, sr_bad, new_err;

    // first valid requester scanning upward from rr_ptr, wrapping at NREQ
    always_comb begin
        any  = 1'b0;
        win  = '0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = SRCW'((int'(rr_ptr_q) + k) % NREQ);
            if (!any && req_valid[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
        gnt      = any ? NREQ'(1) << win : '0;
        rr_ptr_d = any ? ((int'(win) == NREQ - 1) ? '0 : win + 1'b1) : rr_ptr_q;
        op_vld_d = any;
        op_set_d = req_set[win];
        op_clr_d = req_clr[win];
        op_idx_d = req_idx[int'(win)*IDXW +: IDXW];
        op_src_d = win;
    end

    // SR-to-T conversion on the staged command; Q is read from the live bank so
    // back-to-back commands on one flag see the previous result
    always_comb begin
        in_rng = int'(op_idx_q) < NFLAG;
        q_bit  = in_rng ? flags_q[op_idx_q] : 1'b0;
`ifdef SR_FLAG_TOGGLE_EN
        t_bit  = (op_set_q & op_clr_q) ? 1'b1 : op_set_q ? ~q_bit : op_clr_q ? q_bit : 1'b0;
        sr_bad = 1'b0;
`else
        t_bit  = (op_set_q & ~op_clr_q) ? ~q_bit : (op_clr_q & ~op_set_q) ? q_bit : 1'b0;
        sr_bad = op_set_q & op_clr_q;
`endif
        t_bit      = t_bit & in_rng & op_vld_q;
        new_err    = op_vld_q & (~in_rng | sr_bad);
        flags_d    = flags_q ^ (NFLAG'(t_bit) << op_idx_q);
        done_vld_d = op_vld_q;
        done_src_d = op_vld_q ? op_src_q : done_src_q;
        done_chg_d = t_bit;
        // a new error outranks a simultaneous clear
        err_d      = new_err ? 1'b1 : err_clr ? 1'b0 : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            op_vld_q   <= 1'b0;
            op_set_q   <= 1'b0;
            op_clr_q   <= 1'b0;
            op_idx_q   <= '0;
            op_src_q   <= '0;
            flags_q    <= '0;
            done_vld_q <= 1'b0;
            done_src_q <= '0;
            done_chg_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            op_vld_q   <= op_vld_d;
            op_set_q   <= op_set_d;
            op_clr_q   <= op_clr_d;
            op_idx_q   <= op_idx_d;
            op_src_q   <= op_src_d;
            flags_q    <= flags_d;
            done_vld_q <= done_vld_d;
            done_src_q <= done_src_d;
            done_chg_q <= done_chg_d;
            err_q      <= err_d;
        end
    end

    assign flags    = flags_q;
    assign done_vld = done_vld_q;
    assign done_src = done_src_q;
    assign done_chg = done_chg_q;
    assign err      = err_q;
endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shares one bank of T-flip-flop status flags between NREQ requesters.
- Each requester issues set/reset commands on one flag index.
- Block arbitrates round-robin, registers the winning command, and converts it to per-bit T (toggle) enables using the SR-to-T rule (set: T=~Q, reset: T=Q, hold: T=0).
- Sits between software/control requesters and the shared flag register; it is the only writer of the flags.

Parameters:
NREQ, 4, number of requesters (2..8)
NFLAG, 8, number of flags in the bank (2..64); IDXW = clog2(NFLAG) derived internally

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  requester i has a command pending
req_set  input  NREQ  command S bit per requester
req_clr  input  NREQ  command R bit per requester
req_idx  input  NREQ*IDXW  flag index per requester, slice i at [i*IDXW +: IDXW]
gnt  output  NREQ  one-hot ready; transfer when req_valid[i] & gnt[i]
flags  output  NFLAG  current flag bank Q
done_vld  output  1  one-cycle pulse: a command was applied
done_src  output  clog2(NREQ)  requester whose command was applied
done_chg  output  1  applied command changed its flag (T was 1)
err  output  1  sticky error flag
err_clr  input  1  synchronous clear of err

Behaviour:
- Reset (async, rst_n=0): flags=0, gnt=0, rr_ptr=0, stage register invalid, done_vld=0, done_src=0, done_chg=0, err=0. A command captured but not yet applied is discarded.
- Arbitration (combinational from req_valid, rr_ptr):
  - Winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - gnt is one-hot on the winner; gnt=0 when no request is valid.
  - gnt never asserts for a requester whose req_valid=0.
- Accept edge E: if any grant, capture {set, clr, idx, src} into stage register (op_vld=1) and set rr_ptr=(winner+1) mod NREQ. No grant: op_vld=0, rr_ptr unchanged.
- Apply edge E+1: T vector is zero except bit idx, where:
  - set&~clr: T=~Q[idx]
  - clr&~set: T=Q[idx]
  - ~set&~clr: T=0 (hold)
  - set&clr: see Optional Feature
  - flags <= flags ^ T. New value is visible after E+1.
- Same edge E+1: done_vld=1, done_src=src, done_chg=T[idx]. done_vld is 0 on cycles with no applied command.
- Throughput: one command per cycle, fully pipelined; arbitration of the next command overlaps apply of the previous.
- Back-to-back commands to the same idx apply in order; the second sees Q already updated by the first, so there is no hazard.
- Range check: idx >= NFLAG (non-power-of-2 NFLAG) makes the command a no-op, sets err, done_vld=1, done_chg=0.
- err handling:
  - err_clr=1 clears err at the next edge.
  - If err_clr coincides with a new error, set wins.
- Requester holding req_valid=1 after grant issues a fresh command; the block does not deduplicate.

Optional Feature:
- Macro: SR_FLAG_TOGGLE_EN
- Defined: set&clr means toggle (T=1, JK-style); done_chg=1; err not affected.
- Undefined: set&clr is the invalid SR case; flag holds (T=0), done_chg=0, err set to 1.

Test Plan:
- Reset mid-op: accept set idx3 from req0, assert rst_n=0 before apply edge -> flags=0x00, done_vld never pulses, err=0, rr_ptr=0.
- Single command: req1 set idx5 -> gnt=0b0010 same cycle, flags=0x20 one edge after accept, done_vld=1 with done_src=1 and done_chg=1. Repeat -> flags stays 0x20, done_chg=0.
- Fairness: all four req_valid held high for 8 cycles, each requester setting its own idx -> grant order 0,1,2,3,0,1,2,3 and exactly one gnt bit per cycle.
- Back-to-back same flag: req2 set idx0 then req3 clr idx0 on consecutive cycles -> flags[0] goes 0→1→0 on consecutive edges; both done_chg=1.
- Invalid SR: set=clr=1 on idx7 with flags[7]=0 -> without macro: flags[7]=0, err=1; with SR_FLAG_TOGGLE_EN: flags[7]=1, err=0.
- err clear and range check (NFLAG=6): idx6 command -> err=1, flags unchanged, done_vld=1. Then err_clr=1 -> err=0 next edge. err_clr together with a new error -> err stays 1.
